ahb_lite_ram_responder: RTL and testbench

//  AHB-Lite slave with an internal register-array RAM, programmable wait states and

---
 rtl/ahb_lite_ram_responder_pkg.sv | 29 ++
 rtl/ahb_lite_ram_responder_byte_mask.sv | 37 +++
 rtl/ahb_lite_ram_responder.sv | 143 ++++++++++++++
 tb/tb_ahb_lite_ram_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_ram_responder_pkg.sv
// Shared AHB-Lite encodings and responder FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ahb_lite_ram_responder_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_X8      = 3'd0;
   localparam logic [2:0] HSIZE_X16     = 3'd1;
   localparam logic [2:0] HSIZE_X32     = 3'd2;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/ahb_lite_ram_responder_byte_mask.sv
// Byte-lane mask and alignment check for one AHB-Lite beat.
// Latency: combinational.
// Backpressure: none.
// Ports: size (HSIZE), addr_lo (HADDR[1:0]) -> mask (lane enables), misalign.
// Sizes above x32 give an empty mask; the caller flags them as errors.
module ahb_lite_ram_responder_byte_mask
   import ahb_lite_ram_responder_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] mask,
   output logic       misalign
);

   always_comb begin
      mask     = 4'b0000;
      misalign = 1'b0;
      case (size)
         HSIZE_X8: begin
            mask = 4'b0001 << addr_lo;
         end
         HSIZE_X16: begin
            mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         HSIZE_X32: begin
            mask     = 4'b1111;
            misalign = |addr_lo;
         end
         default: begin
            mask     = 4'b0000;
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ahb_lite_ram_responder.sv
// AHB-Lite RAM slave with programmable wait states and two-cycle ERROR responses.
// Latency: WAIT_STATES+1 cycles per OKAY data phase, 2 cycles for ERROR.
// Backpressure: HREADYOUT held low during wait/ERR1 cycles; bus inputs ignored then.
// Ports: HCLK/HRESET (sync, active high), AHB-Lite address/control/HWDATA in,
//        HRDATA/HREADYOUT/HRESP out. HBURST is accepted but not decoded.
module ahb_lite_ram_responder
   import ahb_lite_ram_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [2:0]  HBURST,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("ahb_lite_ram_responder: WAIT_STATES must be 0..15");
      end
   endgenerate

   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   word_q;
   logic [3:0]              mask_q;
   logic                    write_q;

   logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];

   logic [3:0]              lane_mask;
   logic                    misalign;
   logic                    range_err;
   logic                    acc_err;
   logic                    accept;

   // HBURST and HTRANS[0] carry no information this slave needs.
   logic                    unused_inputs;
   assign unused_inputs = ^{HBURST, HTRANS[0]};

   ahb_lite_ram_responder_byte_mask u_byte_mask (
      .size     (HSIZE),
      .addr_lo  (HADDR[1:0]),
      .mask     (lane_mask),
      .misalign (misalign)
   );

   // Gating with HREADYOUT keeps stall cycles from capturing anything even if
   // HREADY comes from a multi-slave mux.
   assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
   assign range_err = |HADDR[31:ADDR_WIDTH+2];
   assign acc_err   = (HSIZE > HSIZE_X32) | misalign | range_err;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (state_q == ST_ERR2) begin
               HRESP = HRESP_ERROR;
            end
            if (accept) begin
               if (acc_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_INIT;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            cnt_d     = cnt_q - 4'd1;
            // Loaded with WAIT_STATES, so leaving at count 1 gives exactly
            // WAIT_STATES low cycles.
            if (cnt_q <= 4'd1) begin
               state_d = ST_DATA;
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         word_q  <= '0;
         mask_q  <= 4'b0000;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            word_q  <= HADDR[ADDR_WIDTH+1:2];
            mask_q  <= lane_mask;
            // Erroring beats never reach DATA, but keep them from looking like writes.
            write_q <= HWRITE & ~acc_err;
         end
      end
   end

   // RAM contents survive reset; a write still pending when reset hits is dropped.
   always_ff @(posedge HCLK) begin
      if (!HRESET && state_q == ST_DATA && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) begin
               mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   // A write committing at the same edge that latches a following read lands
   // before this lookup, so no forwarding path is needed.
   assign HRDATA = (state_q == ST_DATA && !write_q) ? mem[word_q] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_ram_responder.sv
module tb_ahb_lite_ram_responder;
   import ahb_lite_ram_responder_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hburst, hsize;
   logic [1:0]  htrans;
   logic        hwrite;
   int          dut_sel;

   logic        sel_a, sel_b;
   logic [31:0] rd_a, rd_b;
   logic        ro_a, ro_b, rs_a, rs_b;
   logic [31:0] cur_rd;
   logic        cur_ro, cur_rs;

   assign sel_a  = (dut_sel == 0);
   assign sel_b  = (dut_sel == 1);
   assign cur_rd = sel_a ? rd_a : rd_b;
   assign cur_ro = sel_a ? ro_a : ro_b;
   assign cur_rs = sel_a ? rs_a : rs_b;

   ahb_lite_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel_a), .HADDR(haddr), .HBURST(hburst),
      .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADY(ro_a), .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(rs_a)
   );

   ahb_lite_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel_b), .HADDR(haddr), .HBURST(hburst),
      .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADY(ro_b), .HRDATA(rd_b), .HREADYOUT(ro_b), .HRESP(rs_b)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ba [4];
   logic [31:0] bwd[4];
   logic [31:0] brd[4];
   logic        bwr[4];
   logic [2:0]  bsz[4];
   logic        brs[4];
   int          stalls;
   logic        stall_resp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pipelined AHB-Lite master: beat k address overlaps beat k-1 data phase.
   task automatic run(input int n, input logic burst);
      stalls     = 0;
      stall_resp = 1'b0;
      haddr  = ba[0];
      hwrite = bwr[0];
      hsize  = bsz[0];
      htrans = HTRANS_NONSEQ;
      for (int k = 0; k <= n; k++) begin
         int   guard;
         logic rdy;
         guard = 0;
         forever begin
            @(negedge clk);
            rdy = cur_ro;
            if (!rdy) begin
               stalls++;
               stall_resp = stall_resp | cur_rs;
            end else if (k > 0) begin
               brd[k-1] = cur_rd;
               brs[k-1] = cur_rs;
            end
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 40) begin
               checks++;
               errors++;
               $error("FAIL timeout: HREADYOUT stuck low on beat %0d", k);
               break;
            end
         end
         if (k + 1 < n) begin
            haddr  = ba[k+1];
            hwrite = bwr[k+1];
            hsize  = bsz[k+1];
            htrans = burst ? HTRANS_SEQ : HTRANS_NONSEQ;
         end else begin
            htrans = HTRANS_IDLE;
         end
         if (k < n) hwdata = bwd[k];
      end
   endtask

   task automatic single(input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
      ba[0] = a; bwd[0] = wd; bwr[0] = wr; bsz[0] = sz;
      run(1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; dut_sel = 0;
      haddr = 32'h0; hwdata = 32'h0; hburst = HBURST_SINGLE;
      hsize = HSIZE_X32; htrans = HTRANS_IDLE; hwrite = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset hreadyout", {31'd0, ro_a}, 32'd1);
      check("reset hresp",     {31'd0, rs_a}, 32'd0);
      check("reset hrdata",    rd_a, 32'h0);
      check("reset ws0 hreadyout/hresp", {30'd0, ro_b, rs_b}, 32'd2);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: two wait states on write and read
      single(1'b1, HSIZE_X32, 32'h10, 32'hDEADBEEF);
      check("t1 wr stalls", 32'(stalls), 32'd2);
      check("t1 wr resp",   {31'd0, brs[0] | stall_resp}, 32'd0);
      single(1'b0, HSIZE_X32, 32'h10, 32'h0);
      check("t1 rd stalls", 32'(stalls), 32'd2);
      check("t1 rd data",   brd[0], 32'hDEADBEEF);
      check("t1 rd resp",   {31'd0, brs[0] | stall_resp}, 32'd0);

      // back-to-back write/read of one word with wait states
      ba[0] = 32'h14; bwr[0] = 1'b1; bsz[0] = HSIZE_X32; bwd[0] = 32'hA5A50001;
      ba[1] = 32'h14; bwr[1] = 1'b0; bsz[1] = HSIZE_X32; bwd[1] = 32'h0;
      run(2, 1'b0);
      check("t1 b2b stalls", 32'(stalls), 32'd4);
      check("t1 b2b data",   brd[1], 32'hA5A50001);

      // 2: zero wait states, write then read next cycle
      dut_sel = 1;
      ba[0] = 32'h20; bwr[0] = 1'b1; bsz[0] = HSIZE_X32; bwd[0] = 32'h11223344;
      ba[1] = 32'h20; bwr[1] = 1'b0; bsz[1] = HSIZE_X32; bwd[1] = 32'h0;
      run(2, 1'b0);
      check("t2 stalls", 32'(stalls), 32'd0);
      check("t2 data",   brd[1], 32'h11223344);
      dut_sel = 0;

      // 3: byte lane merge
      single(1'b1, HSIZE_X32, 32'h30, 32'h00000000);
      single(1'b1, HSIZE_X8,  32'h31, 32'h0000AA00);
      single(1'b1, HSIZE_X16, 32'h32, 32'hBBCC0000);
      single(1'b0, HSIZE_X32, 32'h30, 32'h0);
      check("t3 merged word", brd[0], 32'hBBCCAA00);
      single(1'b1, HSIZE_X8,  32'h33, 32'h11FFFFFF);
      single(1'b0, HSIZE_X8,  32'h30, 32'h0);
      check("t3 x8 lane3 + full-word read", brd[0], 32'h11CCAA00);

      // 4: error responses, RAM untouched
      single(1'b1, HSIZE_X32, 32'h04, 32'hCAFEF00D);
      single(1'b0, HSIZE_X32, 32'h06, 32'h0);
      check("t4 misalign stalls",   32'(stalls), 32'd1);
      check("t4 misalign err1/err2", {30'd0, stall_resp, brs[0]}, 32'd3);
      single(1'b0, HSIZE_X32, 32'h00001000, 32'h0);
      check("t4 range stalls",      32'(stalls), 32'd1);
      check("t4 range err1/err2",   {30'd0, stall_resp, brs[0]}, 32'd3);
      single(1'b1, HSIZE_X32, 32'h06, 32'hFFFFFFFF);
      check("t4 misalign wr err",   {31'd0, brs[0]}, 32'd1);
      single(1'b1, HSIZE_X16, 32'h05, 32'hFFFFFFFF);
      check("t4 x16 misalign err",  {31'd0, brs[0]}, 32'd1);
      single(1'b1, 3'd3,      32'h04, 32'hFFFFFFFF);
      check("t4 size err",          {31'd0, brs[0]}, 32'd1);
      single(1'b0, HSIZE_X32, 32'h04, 32'h0);
      check("t4 ram unchanged",     brd[0], 32'hCAFEF00D);
      check("t4 ram unchanged okay", {31'd0, brs[0]}, 32'd0);
      single(1'b1, HSIZE_X32, 32'h00000FFC, 32'h0BADC0DE);
      single(1'b0, HSIZE_X32, 32'h00000FFC, 32'h0);
      check("t4 last word data",    brd[0], 32'h0BADC0DE);
      check("t4 last word okay",    {31'd0, brs[0]}, 32'd0);

      // 5: WRAP4 write then read back
      hburst = HBURST_WRAP4;
      ba[0] = 32'h48; ba[1] = 32'h4C; ba[2] = 32'h40; ba[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         bwr[i] = 1'b1; bsz[i] = HSIZE_X32; bwd[i] = 32'(i + 1);
      end
      run(4, 1'b1);
      check("t5 wr stalls", 32'(stalls), 32'd8);
      for (int i = 0; i < 4; i++) bwr[i] = 1'b0;
      run(4, 1'b1);
      check("t5 rd beat0", brd[0], 32'd1);
      check("t5 rd beat1", brd[1], 32'd2);
      check("t5 rd beat2", brd[2], 32'd3);
      check("t5 rd beat3", brd[3], 32'd4);
      hburst = HBURST_SINGLE;

      // 6: reset during the wait of a write drops it
      single(1'b1, HSIZE_X32, 32'h60, 32'h12345678);
      haddr = 32'h60; hwrite = 1'b1; hsize = HSIZE_X32; htrans = HTRANS_NONSEQ;
      @(posedge clk); #1;
      htrans = HTRANS_IDLE; hwdata = 32'h00000055;
      @(negedge clk);
      check("t6 in wait", {31'd0, ro_a}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("t6 ready after reset", {31'd0, ro_a}, 32'd1);
      check("t6 resp after reset",  {31'd0, rs_a}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      single(1'b0, HSIZE_X32, 32'h60, 32'h0);
      check("t6 prior value kept", brd[0], 32'h12345678);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
